// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle basic ops plus a radix-2 multiply/divide engine.
// Mul/div operate on operand magnitudes and fix the sign in a final FIX cycle.
// Handshake: in_valid/in_ready for requests, out_valid/out_ready for results.
module iter_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [19:0]      alu_control,
  input  logic [WIDTH-1:0] alu_src1,
  input  logic [WIDTH-1:0] alu_src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             illegal_op,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);
  // Counter must be able to hold WIDTH itself.
  localparam int unsigned CW  = SHW + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc: product high half / partial remainder; lo: multiplier / dividend-quotient;
  // opb: multiplicand / divisor magnitude.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic             sel_hi_q, sel_hi_d;     // high product half, or remainder
  logic             sign_res_q, sign_res_d; // negate product / quotient
  logic             sign_rem_q, sign_rem_d; // negate remainder
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  // Request decode.
  logic             legal, is_iter, is_mul, is_div_op;
  logic             signed_a, signed_b, want_hi, a_neg, b_neg, div0, ovf, accept;
  logic [WIDTH-1:0] mag_a, mag_b, basic_res;
  logic [SHW-1:0]   shamt;

  // Iteration datapath.
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   step_acc, step_lo, quot_c, rem_c, fix_res;
  logic [2*WIDTH-1:0] prod, prod_c;

  assign in_ready   = ((state_q == StIdle) | ((state_q == StDone) & out_ready)) & ~flush;
  assign accept     = in_valid & in_ready;
  assign out_valid  = (state_q == StDone);
  assign busy       = (state_q == StBusy) | (state_q == StFix);
  assign alu_result = res_q;
  assign zero       = zero_q;
  assign illegal_op = illegal_q;

  // Decode the request: legality, operand signs/magnitudes and short-circuit cases.
  always_comb begin
    legal     = (alu_control != '0) && ((alu_control & (alu_control - 20'd1)) == '0);
    is_mul    = |alu_control[15:12];
    is_div_op = |alu_control[19:16];
    is_iter   = is_mul | is_div_op;
    // Plain mul only needs the low half, which is sign-agnostic.
    signed_a  = alu_control[13] | alu_control[14] | alu_control[16] | alu_control[18];
    signed_b  = alu_control[13] | alu_control[16] | alu_control[18];
    want_hi   = alu_control[13] | alu_control[14] | alu_control[15] |
                alu_control[18] | alu_control[19];
    a_neg     = signed_a & alu_src1[WIDTH-1];
    b_neg     = signed_b & alu_src2[WIDTH-1];
    mag_a     = a_neg ? (-alu_src1) : alu_src1;
    mag_b     = b_neg ? (-alu_src2) : alu_src2;
    div0      = is_div_op & (alu_src2 == '0);
    ovf       = (alu_control[16] | alu_control[18]) &
                (alu_src1 == {1'b1, {(WIDTH-1){1'b0}}}) & (alu_src2 == '1);
    shamt     = alu_src1[SHW-1:0];
  end

  // Single-cycle result for the basic ops.
  always_comb begin
    basic_res = '0;
    unique case (alu_control)
      20'h00001: basic_res = alu_src1 + alu_src2;
      20'h00002: basic_res = alu_src1 - alu_src2;
      20'h00004: basic_res = {{(WIDTH-1){1'b0}}, ($signed(alu_src1) < $signed(alu_src2))};
      20'h00008: basic_res = {{(WIDTH-1){1'b0}}, (alu_src1 < alu_src2)};
      20'h00010: basic_res = alu_src1 & alu_src2;
      20'h00020: basic_res = ~(alu_src1 | alu_src2);
      20'h00040: basic_res = alu_src1 | alu_src2;
      20'h00080: basic_res = alu_src1 ^ alu_src2;
      20'h00100: basic_res = alu_src2 << shamt;
      20'h00200: basic_res = alu_src2 >> shamt;
      20'h00400: basic_res = $signed(alu_src2) >>> shamt;
      20'h00800: basic_res = {alu_src2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default:   basic_res = '0;
    endcase
  end

  // One radix-2 step (shift-add multiply or restoring divide) and final sign fix.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_sh   = {acc_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opb_q};
    div_ge   = ~div_diff[WIDTH];
    step_acc = is_div_q ? (div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0])
                        : mul_sum[WIDTH:1];
    step_lo  = is_div_q ? {lo_q[WIDTH-2:0], div_ge} : {mul_sum[0], lo_q[WIDTH-1:1]};
    prod     = {step_acc, step_lo};
    prod_c   = sign_res_q ? ('0 - prod) : prod;
    quot_c   = sign_res_q ? (-step_lo) : step_lo;
    rem_c    = sign_rem_q ? (-step_acc) : step_acc;
    if (is_div_q) fix_res = sel_hi_q ? rem_c : quot_c;
    else          fix_res = sel_hi_q ? prod_c[2*WIDTH-1:WIDTH] : prod_c[WIDTH-1:0];
  end

  // Next-state: FSM transitions, operand load on acceptance, flush override.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    lo_d       = lo_q;
    opb_d      = opb_q;
    is_div_d   = is_div_q;
    sel_hi_d   = sel_hi_q;
    sign_res_d = sign_res_q;
    sign_rem_d = sign_rem_q;
    res_d      = res_q;
    illegal_d  = illegal_q;

    unique case (state_q)
      StIdle: ;
      StBusy: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        // The last of the WIDTH steps happens in FIX.
        if (cnt_q == CW'(2)) state_d = StFix;
      end
      StFix: begin
        cnt_d     = '0;
        res_d     = fix_res;
        illegal_d = 1'b0;
        state_d   = StDone;
      end
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d   = StDone;
      illegal_d = ~legal;
      if (!legal) begin
        res_d = '0;
      end else if (!is_iter) begin
        res_d = basic_res;
      end else if (div0) begin
        res_d = want_hi ? alu_src1 : '1;
      end else if (ovf) begin
        res_d = want_hi ? '0 : alu_src1;
      end else begin
        state_d    = StBusy;
        cnt_d      = CW'(WIDTH);
        acc_d      = '0;
        lo_d       = is_div_op ? mag_a : mag_b;
        opb_d      = is_div_op ? mag_b : mag_a;
        is_div_d   = is_div_op;
        sel_hi_d   = want_hi;
        sign_res_d = a_neg ^ b_neg;
        sign_rem_d = a_neg;
      end
    end

    if (flush) begin
      state_d   = StIdle;
      cnt_d     = '0;
      res_d     = res_q;
      illegal_d = illegal_q;
    end
  end

  assign zero_d = (res_d == '0);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      lo_q       <= '0;
      opb_q      <= '0;
      is_div_q   <= 1'b0;
      sel_hi_q   <= 1'b0;
      sign_res_q <= 1'b0;
      sign_rem_q <= 1'b0;
      res_q      <= '0;
      zero_q     <= 1'b1;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      lo_q       <= lo_d;
      opb_q      <= opb_d;
      is_div_q   <= is_div_d;
      sel_hi_q   <= sel_hi_d;
      sign_res_q <= sign_res_d;
      sign_rem_q <= sign_rem_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
      illegal_q  <= illegal_d;
    end
  end

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL derive localparam SHW = log2(WIDTH), the shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous abort of any in-flight operation.
REQ-006 in_valid  input  1  request valid.
REQ-007 in_ready  output  1  request accepted when in_valid & in_ready at a rising edge.
REQ-008 alu_control  input  20  one-hot op: [0] add, [1] sub, [2] slt, [3] sltu, [4] and, [5] nor, [6] or, [7] xor, [8] sll, [9] srl, [10] sra, [11] lui, [12] mul, [13] mulh, [14] mulhsu, [15] mulhu, [16] div, [17] divu, [18] rem, [19] remu.
REQ-009 alu_src1, alu_src2  input  WIDTH  operands, sampled only at acceptance.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts when out_valid & out_ready.
REQ-012 alu_result  output  WIDTH  registered result.
REQ-013 zero  output  1  registered (alu_result == 0).
REQ-014 illegal_op  output  1  registered; alu_control at acceptance not exactly one-hot.
REQ-015 busy  output  1  high in BUSY or FIX.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, FIX, DONE.
REQ-017 in_ready SHALL be (IDLE | (DONE & out_ready)) & ~flush.
REQ-018 Ops [0]-[11] and illegal_op SHALL go to DONE on the accepting edge: out_valid after 1 edge.
REQ-019 Basic ops: add/sub modulo 2^WIDTH; slt signed, sltu unsigned, result 0/1 zero-extended; sll/srl/sra shift alu_src2 by alu_src1[SHW-1:0]; lui = {alu_src2[WIDTH/2-1:0], WIDTH/2 zeros}.
REQ-020 Illegal control SHALL produce alu_result 0, zero 1, illegal_op 1.
REQ-021 Mul/div ops SHALL enter BUSY with a bit counter = WIDTH; one radix-2 iteration per BUSY cycle on operand magnitudes (shift-add multiply, restoring divide).
REQ-022 BUSY SHALL go to FIX after WIDTH iterations; FIX applies sign correction and selects low/high product or quotient/remainder, then goes to DONE: out_valid after WIDTH+1 edges.
REQ-023 mul = low WIDTH bits; mulh signed x signed high; mulhsu signed src1 x unsigned src2 high; mulhu unsigned high.
REQ-024 div/rem signed, truncating toward zero; remainder sign follows dividend.
REQ-025 Divisor 0 SHALL short-circuit to DONE in 1 edge: quotient all ones, remainder = alu_src1.
REQ-026 div/rem with src1 = most-negative and src2 = all ones SHALL short-circuit in 1 edge: quotient = src1, remainder 0.
REQ-027 DONE SHALL hold out_valid, alu_result, zero, illegal_op stable until out_ready.
REQ-028 DONE with out_ready and no new acceptance SHALL go to IDLE, out_valid 0 next cycle.
REQ-029 DONE with out_ready and a simultaneous acceptance SHALL start the new op on the same edge (basic op: out_valid stays 1 with new result).
REQ-030 flush SHALL take priority over everything except rst: next state IDLE, out_valid 0, result discarded, no acceptance that cycle.
REQ-031 in_valid while not in_ready SHALL be ignored; operands of an in-flight op SHALL be unaffected by input changes.

Reset
REQ-032 rst SHALL immediately force state IDLE, out_valid 0, alu_result 0, zero 1, illegal_op 0, busy 0, counter 0, mid-operation included.
REQ-033 in_ready SHALL be 1 in the first cycle after rst deasserts (flush low).

Verification (WIDTH=32)
REQ-034 add 0x7FFFFFFF,0x00000001 -> out_valid 1 edge later, 0x80000000, zero 0; out_ready held low 5 cycles -> outputs stable.
REQ-035 mulh 0x80000000,0x80000000 -> 0x40000000 after 33 edges, busy high 32 cycles; mul same operands -> 0x00000000, zero 1.
REQ-036 div 0xFFFFFFF9,0x00000002 -> 0xFFFFFFFD; rem same operands -> 0xFFFFFFFF; remu 0xFFFFFFF9,2 -> 0x00000001.
REQ-037 divu 5,0 -> 0xFFFFFFFF after 1 edge; remu 5,0 -> 0x00000005; div 0x80000000,0xFFFFFFFF -> 0x80000000, rem -> 0.
REQ-038 alu_control 0x00003 -> alu_result 0, illegal_op 1, 1 edge; back-to-back: DONE & out_ready with xor 0xF0F0F0F0,0xFFFFFFFF pending -> next cycle 0x0F0F0F0F, out_valid never drops.
REQ-039 divu started, rst pulsed at BUSY cycle 10 -> out_valid 0, busy 0 immediately; flush at BUSY cycle 10 -> IDLE next edge, no result ever emitted.
